// File: rtl/b_op_scheduler_pkg.sv
// Shared definitions for the B-port operation scheduler: op codes and FSM state encoding.
package b_op_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    localparam logic [2:0] OP_ADD2 = 3'd0;
    localparam logic [2:0] OP_SUB2 = 3'd1;
    localparam logic [2:0] OP_OR2  = 3'd2;
    localparam logic [2:0] OP_AND2 = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_SUM  = 3'd6;
    localparam logic [2:0] OP_AVG  = 3'd7;

    // Value b_operation shows before any request has been granted.
    localparam logic [2:0] OP_RESET = OP_OR;

endpackage

// File: rtl/b_op_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i wins.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    logic [PTR_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = PTR_W'((int'(ptr_i) + k) % N);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                idx_o          = cand;
                grant_o[cand]  = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/b_op_scheduler.sv
// Round-robin sharing of the single B result port between NUM_REQ requesters,
// with a watchdog that turns a stalled B transaction into an error response.
module b_op_scheduler
    import b_op_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [3*NUM_REQ-1:0] req_op,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [DATA_W-1:0]    rsp_data,
    output logic                 rsp_err,
    input  logic                 b_valid,
    input  logic [DATA_W-1:0]    b_result,
    output logic                 b_ready,
    output logic [2:0]           b_operation
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [2:0]           b_op_q, b_op_d;
    logic                 b_ready_q, b_ready_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]   arb_grant;
    logic [PTR_W-1:0]     arb_idx;
    logic                 arb_any;
    logic [2:0]           op_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_op_unpack
        assign op_arr[g] = req_op[3*g +: 3];
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        wd_d        = wd_q;
        b_op_d      = b_op_q;
        b_ready_d   = b_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    owner_d   = arb_idx;
                    b_op_d    = op_arr[arb_idx];
                    b_ready_d = 1'b1;
                    wd_d      = '0;
                    ptr_d     = (arb_idx == PTR_LAST) ? '0 : arb_idx + 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A real handshake wins over a watchdog expiring in the same cycle.
                if (b_valid && b_ready_q) begin
                    rsp_data_d           = b_result;
                    rsp_err_d            = 1'b0;
                    b_ready_d            = 1'b0;
                    rsp_valid_d          = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = ST_RESP;
                end else if (wd_q == WD_LAST) begin
                    rsp_data_d           = '0;
                    rsp_err_d            = 1'b1;
                    b_ready_d            = 1'b0;
                    rsp_valid_d          = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = ST_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            wd_q        <= '0;
            b_op_q      <= OP_RESET;
            b_ready_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            wd_q        <= wd_d;
            b_op_q      <= b_op_d;
            b_ready_q   <= b_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign b_ready     = b_ready_q;
    assign b_operation = b_op_q;

endmodule

// File: tb/tb_b_op_scheduler.sv
// Bench for b_op_scheduler: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_b_op_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [3*NUM_REQ-1:0] req_op;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [NUM_REQ-1:0]   rsp_ready;
    logic [DATA_W-1:0]    rsp_data;
    logic                 rsp_err;
    logic                 b_valid;
    logic [DATA_W-1:0]    b_result;
    logic                 b_ready;
    logic [2:0]           b_operation;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    b_op_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .b_valid     (b_valid),
        .b_result    (b_result),
        .b_ready     (b_ready),
        .b_operation (b_operation)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: phase 0 = free, 1 = B transaction outstanding, 2 = response waiting.
    int                 m_phase, m_owner, m_ptr, m_issue_cycles, m_w;
    logic [2:0]         m_bop;
    logic               m_bready;
    logic [NUM_REQ-1:0] m_rspv;
    logic [DATA_W-1:0]  m_data;
    logic               m_err;

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int start);
        for (int k = 0; k < NUM_REQ; k++)
            if (((v >> ((start + k) % NUM_REQ)) & 1) != 0) return (start + k) % NUM_REQ;
        return -1;
    endfunction

    assign m_w = pick(req_valid, m_ptr);

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0; m_owner <= 0; m_ptr <= 0; m_issue_cycles <= 0;
            m_bop <= 3'd4; m_bready <= 1'b0; m_rspv <= '0; m_data <= '0; m_err <= 1'b0;
        end else if (m_phase == 0) begin
            if (m_w >= 0) begin
                m_owner <= m_w; m_bop <= 3'(req_op >> (3 * m_w)); m_bready <= 1'b1;
                m_issue_cycles <= 0; m_ptr <= (m_w + 1) % NUM_REQ; m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            if (b_valid) begin
                m_data <= b_result; m_err <= 1'b0; m_bready <= 1'b0;
                m_rspv <= NUM_REQ'(1) << m_owner; m_phase <= 2;
            end else if (m_issue_cycles + 1 == TIMEOUT) begin
                m_data <= '0; m_err <= 1'b1; m_bready <= 1'b0;
                m_rspv <= NUM_REQ'(1) << m_owner; m_phase <= 2;
            end else begin
                m_issue_cycles <= m_issue_cycles + 1;
            end
        end else begin
            if (((rsp_ready >> m_owner) & 1) != 0) begin
                m_rspv <= '0; m_phase <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", req_ready, (m_phase == 0 && m_w >= 0) ? (64'd1 << m_w) : 64'd0);
            chk("rsp_valid", rsp_valid, m_rspv);
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_err", rsp_err, m_err);
            chk("b_ready", b_ready, m_bready);
            chk("b_operation", b_operation, m_bop);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = '0; b_valid = 1'b1; rsp_ready = '1;
        repeat (4) step();
        b_valid = 1'b0; rsp_ready = '0;
    endtask

    int grants[$];
    int cnt;

    initial begin
        rst = 1'b1; req_valid = '0; req_op = '0; rsp_ready = '0; b_valid = 1'b0; b_result = '0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_b_operation", b_operation, 3'd4);
        chk("reset_b_ready", b_ready, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 4'b0000);
        chk("reset_rsp_data", rsp_data, 32'h0);
        chk("reset_rsp_err", rsp_err, 1'b0);

        // Single request, B answers in the third ISSUE cycle
        step(); req_valid = 4'b0001; req_op = 12'd6;
        @(negedge clk); chk("t1_req_ready", req_ready, 4'b0001);
        step(); req_valid = '0;
        @(negedge clk); chk("t1_b_operation", b_operation, 3'd6); chk("t1_b_ready", b_ready, 1'b1);
        step();
        step(); b_valid = 1'b1; b_result = 32'h0000_00AA;
        step(); b_valid = 1'b0;
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 4'b0001); chk("t1_rsp_data", rsp_data, 32'hAA);
        chk("t1_rsp_err", rsp_err, 1'b0); chk("t1_b_op_held", b_operation, 3'd6);
        step(); rsp_ready = 4'b0001;
        step(); rsp_ready = '0;

        // Watchdog
        step(); req_valid = 4'b0100; req_op = 12'd7 << 6;
        @(negedge clk); chk("t3_req_ready", req_ready, 4'b0100);
        step(); req_valid = '0;
        cnt = 0;
        for (int c = 0; c < TIMEOUT + 20; c++) begin
            @(negedge clk);
            if (b_ready) cnt++;
            else break;
        end
        chk("t3_issue_cycles", cnt, TIMEOUT);
        chk("t3_rsp_err", rsp_err, 1'b1); chk("t3_rsp_data", rsp_data, 32'h0);
        chk("t3_rsp_valid", rsp_valid, 4'b0100); chk("t3_b_operation", b_operation, 3'd7);
        step(); rsp_ready = 4'b0100;
        step(); rsp_ready = '0;

        // b_valid outside ISSUE is ignored
        step(); b_valid = 1'b1; b_result = 32'h1234;
        step(); b_valid = 1'b0;
        @(negedge clk); chk("t4_idle_ignore", rsp_data, 32'h0); chk("t4_idle_no_rsp", rsp_valid, 4'b0000);
        step(); req_valid = 4'b0010; req_op = 12'd3 << 3;
        step(); req_valid = '0; b_valid = 1'b1; b_result = 32'h5678;
        step(); b_valid = 1'b0;
        @(negedge clk); chk("t4_capture", rsp_data, 32'h5678); chk("t4_rsp_valid", rsp_valid, 4'b0010);
        step(); b_valid = 1'b1; b_result = 32'h1234;
        step(); b_valid = 1'b0;
        @(negedge clk); chk("t4_resp_ignore", rsp_data, 32'h5678);
        step(); rsp_ready = 4'b0010;
        step(); rsp_ready = '0;

        // Long RESP hold with competing requesters and non-winner rsp_ready
        step(); req_valid = 4'b1000; req_op = 12'd5 << 9;
        step(); req_valid = '0; b_valid = 1'b1; b_result = 32'hCAFE;
        step(); b_valid = 1'b0; req_valid = 4'b0111; rsp_ready = 4'b0111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t6_no_grant", req_ready, 4'b0000); chk("t6_data_stable", rsp_data, 32'hCAFE);
            chk("t6_err_stable", rsp_err, 1'b0); chk("t6_rsp_valid", rsp_valid, 4'b1000);
        end
        step(); rsp_ready = 4'b1000;
        @(negedge clk); chk("t6_accept_cycle_no_grant", req_ready, 4'b0000);
        step(); rsp_ready = '0;
        @(negedge clk); chk("t6_next_grant_wraps", req_ready, 4'b0001);
        drain();

        // Round-robin order from a fresh pointer
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        req_valid = 4'b1111; req_op = {3'd3, 3'd2, 3'd1, 3'd0}; b_valid = 1'b1; rsp_ready = 4'b1111;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++)
                if (((req_ready >> i) & 1) != 0) grants.push_back(i);
            step(); b_result = 32'h100 + DATA_W'(c);
        end
        chk("t2_grant_count_ge8", grants.size() >= 8, 1'b1);
        for (int k = 0; k < 8 && k < grants.size(); k++) chk("t2_grant_order", grants[k], k % NUM_REQ);
        drain();
        @(negedge clk); chk("t2_drained", rsp_valid, 4'b0000);

        // Reset in the middle of a transaction
        step(); req_valid = 4'b0001; req_op = 12'd2;
        step(); req_valid = '0; rst = 1'b1;
        @(negedge clk); chk("t5_pre_reset_b_ready", b_ready, 1'b1);
        step(); rst = 1'b0;
        @(negedge clk);
        chk("t5_b_operation", b_operation, 3'd4); chk("t5_b_ready", b_ready, 1'b0);
        chk("t5_rsp_valid", rsp_valid, 4'b0000); chk("t5_rsp_data", rsp_data, 32'h0);
        step(); b_valid = 1'b1; b_result = 32'hBEEF;
        repeat (3) step();
        b_valid = 1'b0;
        @(negedge clk); chk("t5_no_response", rsp_valid, 4'b0000);

        step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
